// File: rtl/isqrt_seq.sv
// isqrt_seq: sequential restoring integer square root.
// One root bit per clock; root/remainder registered at completion.
module isqrt_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   radicand,
    output logic               busy,
    output logic               done,
    output logic [WIDTH/2-1:0] root,
    output logic [WIDTH/2:0]   remainder
);

    localparam int H  = WIDTH / 2;
    localparam int CW = (H > 1) ? $clog2(H) : 1;

    generate
        if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("isqrt_seq: WIDTH must be even and at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    logic [WIDTH-1:0] op_q;
    logic [H-1:0]   root_q;
    logic [H:0]     rem_q;
    logic [CW-1:0]  cnt;

    logic [1:0]     pair;
    logic [H+2:0]   shifted;
    logic [H+2:0]   sub_val;
    logic [H+2:0]   trial;
    logic           neg;
    logic [H-1:0]   root_nx;
    logic [H:0]     rem_nx;
    logic           unused_msb;

    // Kept one bit wider than the sign position so nothing is ever lost.
    assign pair       = op_q[WIDTH-1 -: 2];
    assign shifted    = {rem_q, pair};
    assign sub_val    = {1'b0, root_q, 2'b01};
    assign trial      = shifted - sub_val;
    assign neg        = trial[H+2];
    assign root_nx    = neg ? (root_q << 1) : ((root_q << 1) | H'(1));
    assign rem_nx     = neg ? shifted[H:0] : trial[H:0];
    assign unused_msb = trial[H+1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            op_q      <= '0;
            root_q    <= '0;
            rem_q     <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            root      <= '0;
            remainder <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q   <= radicand;
                        root_q <= '0;
                        rem_q  <= '0;
                        cnt    <= CW'(H - 1);
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    op_q   <= op_q << 2;
                    root_q <= root_nx;
                    rem_q  <= rem_nx;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
                        root      <= root_nx;
                        remainder <= rem_nx;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_isqrt_seq.sv
// tb_isqrt_seq: directed vectors and corner sequences
// for isqrt_seq at WIDTH=8 and WIDTH=16.
module tb_isqrt_seq;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start8, start16;
    logic [7:0]  rad8;
    logic [15:0] rad16;
    logic        busy8, done8, busy16, done16;
    logic [3:0]  root8;
    logic [4:0]  rem8;
    logic [7:0]  root16;
    logic [8:0]  rem16;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    isqrt_seq #(.WIDTH(8)) u_dut8 (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start8),
        .radicand  (rad8),
        .busy      (busy8),
        .done      (done8),
        .root      (root8),
        .remainder (rem8)
    );

    isqrt_seq #(.WIDTH(16)) u_dut16 (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start16),
        .radicand  (rad16),
        .busy      (busy16),
        .done      (done16),
        .root      (root16),
        .remainder (rem16)
    );

    typedef struct {
        int w;
        int x;
        int r;
        int m;
        int lat;
    } vec_t;

    vec_t vecs [8] = '{
        '{8,   0,     0,   0,   4},
        '{8,   1,     1,   0,   4},
        '{8,   144,   12,  0,   4},
        '{8,   143,   11,  22,  4},
        '{8,   255,   15,  30,  4},
        '{16,  65535, 255, 510, 8},
        '{16,  40000, 200, 0,   8},
        '{16,  2,     1,   1,   8}
    };

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_root(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic op(input int w, input int x,
                      output int r, output int m, output int lat);
        @(negedge clock);
        if (w == 8) begin
            start8 = 1'b1;
            rad8   = x[7:0];
        end else begin
            start16 = 1'b1;
            rad16   = x[15:0];
        end
        @(posedge clock);
        #1;
        start8  = 1'b0;
        start16 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock);
            #1;
            if ((w == 8) ? done8 : done16) begin
                lat = c;
                break;
            end
        end
        r = (w == 8) ? int'(root8) : int'(root16);
        m = (w == 8) ? int'(rem8) : int'(rem16);
    endtask

    initial begin
        int r, m, lat;
        int t1, t2, bad, nd, td, rr, rm;

        reset_n = 1'b0;
        start8  = 1'b0;
        start16 = 1'b0;
        rad8    = '0;
        rad16   = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset busy", int'(busy8), 0);
        chk("reset done", int'(done8), 0);
        chk("reset root", int'(root8), 0);
        chk("reset rem", int'(rem8), 0);
        chk("reset done16", int'(done16), 0);
        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            op(vecs[i].w, vecs[i].x, r, m, lat);
            chk($sformatf("vec%0d lat", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d root", i), r, vecs[i].r);
            chk($sformatf("vec%0d rem", i), m, vecs[i].m);
        end

        for (int x = 0; x < 256; x++) begin
            op(8, x, r, m, lat);
            chk($sformatf("sweep %0d lat", x), lat, 4);
            chk($sformatf("sweep %0d root", x), r, ref_root(x));
            chk($sformatf("sweep %0d r2+m", x), r * r + m, x);
            chk($sformatf("sweep %0d m<=2r", x), int'(m <= 2 * r), 1);
        end

        // Abort mid-run: root8 still holds 15 from the sweep.
        @(negedge clock);
        start8 = 1'b1;
        rad8   = 8'd200;
        @(posedge clock);
        #1;
        start8 = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort busy", int'(busy8), 0);
        chk("abort done", int'(done8), 0);
        chk("abort root", int'(root8), 0);
        chk("abort rem", int'(rem8), 0);
        @(negedge clock);
        reset_n = 1'b1;
        bad = 0;
        repeat (6) begin
            @(posedge clock);
            #1;
            if (done8 || busy8) bad++;
        end
        chk("abort no done", bad, 0);
        op(8, 200, r, m, lat);
        chk("after abort lat", lat, 4);
        chk("after abort root", r, 14);
        chk("after abort rem", m, 4);

        // Back-to-back with start held high.
        @(negedge clock);
        start8 = 1'b1;
        rad8   = 8'd255;
        @(posedge clock);
        #1;
        t1 = -1;
        t2 = -1;
        bad = 0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clock);
            #1;
            if (busy8 == done8) bad++;
            if (done8) begin
                if (t1 < 0) begin
                    t1 = c;
                    chk("b2b root1", int'(root8), 15);
                    chk("b2b rem1", int'(rem8), 30);
                    rad8 = 8'd16;
                end else begin
                    t2 = c;
                    chk("b2b root2", int'(root8), 4);
                    chk("b2b rem2", int'(rem8), 0);
                end
            end
        end
        start8 = 1'b0;
        chk("b2b busy vs done", bad, 0);
        chk("b2b first done", t1, 4);
        chk("b2b second done", t2, 9);
        repeat (2) @(posedge clock);

        // Start while busy is dropped.
        @(negedge clock);
        start8 = 1'b1;
        rad8   = 8'd99;
        @(posedge clock);
        #1;
        start8 = 1'b0;
        nd = 0;
        td = -1;
        rr = -1;
        rm = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clock);
            #1;
            if (done8) begin
                nd++;
                if (nd == 1) begin
                    td = c;
                    rr = int'(root8);
                    rm = int'(rem8);
                end
            end
            if (c == 2) begin
                start8 = 1'b1;
                rad8   = 8'd4;
            end
            if (c == 3) start8 = 1'b0;
        end
        chk("busy-start dones", nd, 1);
        chk("busy-start lat", td, 4);
        chk("busy-start root", rr, 9);
        chk("busy-start rem", rm, 18);

        // Output hold while radicand toggles.
        op(8, 63, r, m, lat);
        chk("hold root", r, 7);
        chk("hold rem", m, 14);
        bad = 0;
        repeat (10) begin
            @(negedge clock);
            rad8 = ~rad8;
            @(posedge clock);
            #1;
            if (root8 != 4'd7 || rem8 != 5'd14 || done8 || busy8) bad++;
        end
        chk("hold stable", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
